// File: rtl/trap_redirect_pkg.sv
// Shared constants and types for the trap sequencer and its decoder.
package trap_redirect_pkg;

  localparam logic [6:0]  SYSTEM_OPCODE = 7'b1110011;
  localparam logic [11:0] FUNCT12_ECALL = 12'h000;
  localparam logic [11:0] FUNCT12_MRET  = 12'h302;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_TRAP     = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  typedef enum logic {
    KIND_ECALL = 1'b0,
    KIND_MRET  = 1'b1
  } trap_kind_t;

endpackage

// File: rtl/trap_redirect_if.sv
// Redirect channel from the trap sequencer (master) to instruction fetch (slave).
// Handshake: the master raises redirect_valid with redirect_pc and holds both
// stable until a cycle where redirect_ready is also high; that cycle is the
// transfer. redirect_ready may be high at any time and has no effect without valid.
interface trap_redirect_if #(
  parameter int XLEN = 64
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            redirect_ready;

  modport master (
    output redirect_valid,
    output redirect_pc,
    input  redirect_ready
  );

  modport slave (
    input  redirect_valid,
    input  redirect_pc,
    output redirect_ready
  );
endinterface

// File: rtl/trap_decode.sv
// Combinational ECALL / MRET detector for a retiring instruction word.
module trap_decode
  import trap_redirect_pkg::*;
#(
  parameter int INST_LEN = 32
) (
  input  logic [INST_LEN-1:0] instr,
  input  logic                valid,
  output logic                is_ecall,
  output logic                is_mret
);

  logic sys_base;

  // A system op with funct3, rs1 and rd all zero; funct12 then picks the kind
  always_comb begin
    sys_base = valid
             && (instr[6:0]   == SYSTEM_OPCODE)
             && (instr[14:12] == 3'b000)
             && (instr[19:15] == 5'd0)
             && (instr[11:7]  == 5'd0);
    is_ecall = sys_base && (instr[31:20] == FUNCT12_ECALL);
    is_mret  = sys_base && (instr[31:20] == FUNCT12_MRET);
  end

endmodule

// File: rtl/trap_redirect.sv
// Trap sequencer between WB and the CSR file: pulses trap for a retiring
// ECALL/MRET, flushes the pipe and offers mtvec/mepc to fetch.
// Optional feature macro: TRAP_CNT_EN adds a 64-bit TRAP-cycle counter port.
module trap_redirect
  import trap_redirect_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int INST_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_valid_i,
  input  logic [XLEN-1:0]     wb_pc_i,
  input  logic [INST_LEN-1:0] wb_instr_i,
  input  logic [XLEN-1:0]     mtvec_i,
  input  logic [XLEN-1:0]     mepc_i,
  output logic                trap_o,
  output logic [XLEN-1:0]     csr_pc_o,
  output logic [INST_LEN-1:0] csr_instr_o,
  output logic                flush_o,
  output logic                wb_stall_o,
`ifdef TRAP_CNT_EN
  output logic [63:0]         trap_cnt_o,
`endif
  output state_t              dbg_state_o,
  trap_redirect_if.master     redir
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~{{(XLEN-2){1'b0}}, 2'b11};

  state_t                state_q, state_d;
  trap_kind_t            kind_q, kind_d;
  logic                  trap_q, trap_d;
  logic                  flush_q, flush_d;
  logic                  stall_q, stall_d;
  logic                  rvalid_q, rvalid_d;
  logic [XLEN-1:0]       csr_pc_q, csr_pc_d;
  logic [INST_LEN-1:0]   csr_instr_q, csr_instr_d;
  logic [XLEN-1:0]       rpc_q, rpc_d;
  logic                  is_ecall, is_mret;

  trap_decode #(.INST_LEN(INST_LEN)) u_decode (
    .instr    (wb_instr_i),
    .valid    (wb_valid_i),
    .is_ecall (is_ecall),
    .is_mret  (is_mret)
  );

  // Next state and next registered outputs; outputs describe the state being entered
  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    trap_d      = 1'b0;
    flush_d     = 1'b0;
    stall_d     = 1'b0;
    rvalid_d    = 1'b0;
    csr_pc_d    = csr_pc_q;
    csr_instr_d = '0;
    rpc_d       = rpc_q;
    case (state_q)
      ST_IDLE: begin
        csr_pc_d = '0;
        rpc_d    = '0;
        if (is_ecall || is_mret) begin
          state_d     = ST_TRAP;
          kind_d      = is_mret ? KIND_MRET : KIND_ECALL;
          csr_pc_d    = wb_pc_i;
          csr_instr_d = wb_instr_i;
          trap_d      = 1'b1;
          flush_d     = 1'b1;
          stall_d     = 1'b1;
        end
      end
      ST_TRAP: begin
        // Target sampled now, before the CSR trap edge rewrites mepc
        state_d  = ST_REDIRECT;
        rpc_d    = ((kind_q == KIND_MRET) ? mepc_i : mtvec_i) & ALIGN_MASK;
        rvalid_d = 1'b1;
        flush_d  = 1'b1;
        stall_d  = 1'b1;
      end
      ST_REDIRECT: begin
        if (redir.redirect_ready) begin
          state_d  = ST_IDLE;
          csr_pc_d = '0;
          rpc_d    = '0;
        end else begin
          rvalid_d = 1'b1;
          flush_d  = 1'b1;
          stall_d  = 1'b1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        csr_pc_d = '0;
        rpc_d    = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      kind_q      <= KIND_ECALL;
      trap_q      <= 1'b0;
      flush_q     <= 1'b0;
      stall_q     <= 1'b0;
      rvalid_q    <= 1'b0;
      csr_pc_q    <= '0;
      csr_instr_q <= '0;
      rpc_q       <= '0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      trap_q      <= trap_d;
      flush_q     <= flush_d;
      stall_q     <= stall_d;
      rvalid_q    <= rvalid_d;
      csr_pc_q    <= csr_pc_d;
      csr_instr_q <= csr_instr_d;
      rpc_q       <= rpc_d;
    end
  end

`ifdef TRAP_CNT_EN
  logic [63:0] cnt_q, cnt_d;

  // One count per cycle spent in TRAP; natural wrap at 2^64
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_TRAP) cnt_d = cnt_q + 64'd1;
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign trap_cnt_o = cnt_q;
`endif

  assign trap_o               = trap_q;
  assign flush_o              = flush_q;
  assign wb_stall_o           = stall_q;
  assign csr_pc_o             = csr_pc_q;
  assign csr_instr_o          = csr_instr_q;
  assign redir.redirect_valid = rvalid_q;
  assign redir.redirect_pc    = rpc_q;
  assign dbg_state_o          = state_q;

endmodule

// File: tb/tb_trap_redirect.sv
// Directed bench for trap_redirect: reset, ECALL, MRET with backpressure,
// alignment, non-trap encodings, back-to-back entry and mid-flight reset.
module tb_trap_redirect;
  import trap_redirect_pkg::*;

  localparam logic [31:0] I_ECALL  = 32'h0000_0073;
  localparam logic [31:0] I_MRET   = 32'h3020_0073;
  localparam logic [31:0] I_EBREAK = 32'h0010_0073;
  localparam logic [31:0] I_CSRRW  = 32'h3001_1073;
  localparam logic [31:0] I_ADDI   = 32'h0010_0093;
  localparam logic [31:0] I_ECALL_RD = 32'h0000_00F3;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [63:0] wb_pc;
  logic [31:0] wb_instr;
  logic [63:0] mtvec;
  logic [63:0] mepc;
  logic        trap;
  logic [63:0] csr_pc;
  logic [31:0] csr_instr;
  logic        flush;
  logic        wb_stall;
  state_t      dbg_state;
`ifdef TRAP_CNT_EN
  logic [63:0] trap_cnt;
`endif

  int total = 0;
  int bad   = 0;

  trap_redirect_if #(.XLEN(64)) rif ();

  trap_redirect #(.XLEN(64), .INST_LEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .wb_valid_i  (wb_valid),
    .wb_pc_i     (wb_pc),
    .wb_instr_i  (wb_instr),
    .mtvec_i     (mtvec),
    .mepc_i      (mepc),
    .trap_o      (trap),
    .csr_pc_o    (csr_pc),
    .csr_instr_o (csr_instr),
    .flush_o     (flush),
    .wb_stall_o  (wb_stall),
`ifdef TRAP_CNT_EN
    .trap_cnt_o  (trap_cnt),
`endif
    .dbg_state_o (dbg_state),
    .redir       (rif.master)
  );

  // Clock
  always #5 clk = ~clk;

  // Advance one edge; outputs are then sampled 1 ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".state"},  64'(dbg_state), 64'(ST_IDLE));
    check({tag, ".trap"},   64'(trap), 64'd0);
    check({tag, ".flush"},  64'(flush), 64'd0);
    check({tag, ".stall"},  64'(wb_stall), 64'd0);
    check({tag, ".rvalid"}, 64'(rif.redirect_valid), 64'd0);
    check({tag, ".csrpc"},  csr_pc, 64'd0);
    check({tag, ".csrins"}, 64'(csr_instr), 64'd0);
    check({tag, ".rpc"},    rif.redirect_pc, 64'd0);
  endtask

  task automatic check_trap(input string tag, input logic [63:0] pc, input logic [31:0] ins);
    check({tag, ".state"},  64'(dbg_state), 64'(ST_TRAP));
    check({tag, ".trap"},   64'(trap), 64'd1);
    check({tag, ".flush"},  64'(flush), 64'd1);
    check({tag, ".stall"},  64'(wb_stall), 64'd1);
    check({tag, ".rvalid"}, 64'(rif.redirect_valid), 64'd0);
    check({tag, ".csrpc"},  csr_pc, pc);
    check({tag, ".csrins"}, 64'(csr_instr), 64'(ins));
  endtask

  task automatic check_redir(input string tag, input logic [63:0] rpc);
    check({tag, ".state"},  64'(dbg_state), 64'(ST_REDIRECT));
    check({tag, ".trap"},   64'(trap), 64'd0);
    check({tag, ".flush"},  64'(flush), 64'd1);
    check({tag, ".stall"},  64'(wb_stall), 64'd1);
    check({tag, ".rvalid"}, 64'(rif.redirect_valid), 64'd1);
    check({tag, ".rpc"},    rif.redirect_pc, rpc);
    check({tag, ".csrins"}, 64'(csr_instr), 64'd0);
  endtask

  // Present one instruction to WB for a single cycle
  task automatic wb_issue(input logic [63:0] pc, input logic [31:0] ins);
    wb_valid = 1'b1;
    wb_pc    = pc;
    wb_instr = ins;
    tick();
    wb_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    wb_valid = 1'b1;
    wb_pc = 64'h8000_0000;
    wb_instr = I_ADDI;
    mtvec = 64'h8000_0400;
    mepc = 64'h0;
    rif.redirect_ready = 1'b1;

    // Reset for two cycles with an addi in WB
    tick();
    tick();
    check_idle("reset");
`ifdef TRAP_CNT_EN
    check("cnt_reset", trap_cnt, 64'd0);
`endif
    rst = 1'b0;
    tick();
    check_idle("addi_idle");
    wb_valid = 1'b0;

    // ECALL, ready tied high: TRAP, one REDIRECT cycle, then IDLE
    wb_issue(64'h8000_0100, I_ECALL);
    check_trap("ecall_trap", 64'h8000_0100, I_ECALL);
    tick();
    check_redir("ecall_redir", 64'h8000_0400);
    tick();
    check_idle("ecall_done");

    // MRET with backpressure; mepc changes after TRAP must not leak through
    rif.redirect_ready = 1'b0;
    mepc = 64'h8000_0104;
    wb_issue(64'h8000_0180, I_MRET);
    check_trap("mret_trap", 64'h8000_0180, I_MRET);
    tick();
    mepc = 64'h8000_0200;
    check_redir("mret_redir", 64'h8000_0104);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_redir($sformatf("mret_hold%0d", i), 64'h8000_0104);
    end
    rif.redirect_ready = 1'b1;
    tick();
    check_idle("mret_done");

    // Misaligned mtvec; a new ECALL waiting while REDIRECT completes
    mtvec = 64'h8000_0403;
    wb_issue(64'h8000_0300, I_ECALL);
    check_trap("mis_trap", 64'h8000_0300, I_ECALL);
    tick();
    check_redir("mis_redir", 64'h8000_0400);
    wb_valid = 1'b1;
    wb_pc    = 64'h8000_0340;
    wb_instr = I_ECALL;
    tick();
    check_idle("b2b_idle");
    tick();
    check_trap("b2b_trap", 64'h8000_0340, I_ECALL);
    wb_valid = 1'b0;
    tick();
    check_redir("b2b_redir", 64'h8000_0400);
    tick();
    check_idle("b2b_done");
`ifdef TRAP_CNT_EN
    check("cnt_four", trap_cnt, 64'd4);
`endif

    // Encodings that must pass through untouched
    wb_issue(64'h8000_0400, I_EBREAK);
    check_idle("ebreak");
    wb_issue(64'h8000_0404, I_CSRRW);
    check_idle("csrrw");
    wb_issue(64'h8000_0408, I_ECALL_RD);
    check_idle("ecall_rd");
    wb_valid = 1'b0;
    wb_instr = I_ECALL;
    tick();
    check_idle("ecall_novalid");

    // Reset while REDIRECT is waiting for fetch
    mtvec = 64'h8000_0400;
    rif.redirect_ready = 1'b0;
    wb_issue(64'h8000_0500, I_ECALL);
    check_trap("rst_trap", 64'h8000_0500, I_ECALL);
    tick();
    check_redir("rst_redir", 64'h8000_0400);
    rst = 1'b1;
    tick();
    check_idle("rst_mid");
`ifdef TRAP_CNT_EN
    check("cnt_after_rst", trap_cnt, 64'd0);
`endif
    rst = 1'b0;
    rif.redirect_ready = 1'b1;
    tick();
    check_idle("rst_no_reissue");

    // Three ECALLs back to back through the full sequence
    for (int k = 0; k < 3; k++) begin
      wb_issue(64'h8000_0600 + 64'(k * 4), I_ECALL);
      tick();
      tick();
    end
    check_idle("three_done");
`ifdef TRAP_CNT_EN
    check("cnt_three", trap_cnt, 64'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trap_redirect.md
# trap_redirect

Trap sequencer between the write-back stage and the CSR file of the pipelined RV64 core. It detects a retiring `ecall` or `mret` and drives the CSR file's `trap` strobe together with the trapping PC and instruction. It flushes younger pipeline stages and delivers the new fetch PC to IF over a valid/ready handshake: `mtvec` for `ecall`, `mepc` for `mret`.

## Interface
Parameters:
- `XLEN`, 64, datapath width
- `INST_LEN`, 32, instruction width

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- `clk` in 1: core clock
- `rst` in 1: synchronous active-high reset
- `wb_valid_i` in 1: WB holds a retiring instruction this cycle
- `wb_pc_i` in XLEN: PC of the WB instruction
- `wb_instr_i` in INST_LEN: WB instruction word
- `mtvec_i` in XLEN: current mtvec from the CSR file
- `mepc_i` in XLEN: current mepc from the CSR file
- `trap_o` out 1: one-cycle trap strobe to the CSR file
- `csr_pc_o` out XLEN: latched trapping PC, to CSR `pc_i`
- `csr_instr_o` out INST_LEN: latched trapping instruction, to CSR `instr_i` during the trap cycle
- `flush_o` out 1: kill IF/ID/EX/MEM contents
- `wb_stall_o` out 1: WB must hold and must not retire
- `redirect_valid_o` out 1: new fetch PC offered
- `redirect_pc_o` out XLEN: new fetch PC, bits [1:0] forced to 0
- `redirect_ready_i` in 1: IF accepts the redirect

## Operation
- Decode applies to `wb_instr_i`: opcode [6:0]=7'b1110011, funct3=0, rs1=0, rd=0.
  - [31:20]=12'h000 is ECALL.
  - [31:20]=12'h302 is MRET.
  - All other encodings, including ebreak and CSR ops, pass through with no action.
- State machine: IDLE, TRAP, REDIRECT.
- IDLE
  - When `wb_valid_i` and the instruction is ECALL or MRET: latch pc, instr and kind, then go to TRAP.
  - Otherwise stay in IDLE.
- TRAP (exactly 1 cycle)
  - `trap_o`=1, `flush_o`=1, `wb_stall_o`=1.
  - `csr_pc_o` and `csr_instr_o` show the latched values.
  - Target register loads `mtvec_i` (ECALL) or `mepc_i` (MRET), sampled in this cycle, i.e. before the CSR's trap edge rewrites mepc.
  - Next state is REDIRECT.
- REDIRECT
  - `redirect_valid_o`=1, `flush_o`=1, `wb_stall_o`=1.
  - `redirect_pc_o`={target[XLEN-1:2],2'b00}, held stable until accepted.
  - When `redirect_ready_i`=1: go to IDLE.
- Outputs in IDLE and after reset:
  - `trap_o`, `flush_o`, `wb_stall_o` and `redirect_valid_o` are all 0.
  - `csr_pc_o`, `csr_instr_o` and `redirect_pc_o` are all 0.
- `csr_instr_o` is driven to 0 outside TRAP, so CSR decode sees no system op.

## Timing
- A trap instruction seen in IDLE at cycle N produces TRAP at N+1 and REDIRECT at N+2.
- `redirect_ready_i` high at cycle M in REDIRECT returns the block to IDLE at M+1, with `wb_stall_o`=0 from M+1.
  - Minimum occupancy is 2 busy cycles (ready already high at N+2).
- `redirect_ready_i` is ignored in IDLE and TRAP.
- While busy, WB is stalled: a new trap instruction is not sampled until IDLE.
- A trap instruction present in the same cycle the block returns to IDLE is handled normally: IDLE then TRAP the next cycle.
- `rst` asserted in any state returns the block to IDLE next edge with all outputs at reset values. No trap is re-issued; the redirect is lost.
- `wb_valid_i`=0 with a trap encoding present: no action.

## Configuration
- `TRAP_CNT_EN` defined:
  - Adds output port `trap_cnt_o` (64 bits), counting TRAP cycles.
  - Reset value 0; increments by 1 per TRAP cycle; wraps from 2^64-1 to 0.
- `TRAP_CNT_EN` undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package holds:
  - SYSTEM opcode constant 7'b1110011
  - FUNCT12 constants ECALL=12'h000 and MRET=12'h302
  - The 2-bit state enum IDLE/TRAP/REDIRECT
  - The trap kind encoding
- One combinational sub-module, `trap_decode`, takes `instr` and `valid` and outputs `is_ecall` and `is_mret`. It is reused later by the commit-stage exception logic.

## Test plan
- Reset then idle: `rst` for 2 cycles, WB issues `addi`. All outputs stay 0 and the state stays IDLE.
- ECALL:
  - Stimulus: WB ECALL (0x00000073) at pc 0x80000100, mtvec=0x80000400, ready tied high.
  - Response: `trap_o` pulse at N+1 with `csr_pc_o`=0x80000100; at N+2 `redirect_pc_o`=0x80000400 for 1 cycle; IDLE at N+3.
- MRET:
  - Stimulus: WB MRET (0x30200073), mepc_i=0x80000104, mepc_i changed to 0x80000200 at N+2.
  - Response: `redirect_pc_o`=0x80000104, proving the target was latched in TRAP.
- Backpressure:
  - Stimulus: ready low for 5 cycles in REDIRECT.
  - Response: `redirect_valid_o`, `redirect_pc_o`, `flush_o` and `wb_stall_o` held constant; release on the ready cycle and IDLE next.
- Misaligned and non-trap:
  - mtvec=0x80000403 gives redirect 0x80000400.
  - ebreak (0x00100073) and csrrw give no `trap_o`.
- Reset mid-operation: `rst` during REDIRECT gives IDLE next cycle with all outputs 0. With `TRAP_CNT_EN`, the count is 0 after reset and 3 after three ECALLs.
